// File: rtl/voice_allocator_p.sv
// Voice slot table feeding the phase bank with one slot's note per clk_en, round-robin.
// Latency: accepted event lands in the table on the first clk_en edge after acceptance; stream output is registered.
// Backpressure: single holding register; o_ev_ready drops after accept until the event is applied.
module voice_allocator_p #(
  parameter int NBANKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       i_ev_valid,
  input  logic       i_ev_on,
  input  logic [6:0] i_ev_note,
  output logic       o_ev_ready,
  output logic [6:0] o_midi,
  output logic [3:0] o_slot,
  output logic       o_valid,
  output logic [3:0] o_active_count,
  output logic       o_full,
  output logic       o_steal
);

  localparam logic [3:0] LAST = 4'(NBANKS - 1);

  logic [6:0] slot_q [NBANKS];
  logic [6:0] slot_d [NBANKS];
  logic [3:0] ctr_q, ctr_d;
  logic [3:0] steal_ptr_q, steal_ptr_d;
  logic       hold_full_q, hold_full_d;
  logic       hold_on_q, hold_on_d;
  logic [6:0] hold_note_q, hold_note_d;
  logic [6:0] midi_q, midi_d;
  logic [3:0] slot_out_q, slot_out_d;
  logic       valid_q, valid_d;
  // Four bits: with NBANKS = 16 a full table reads 0 here, o_full tells it apart.
  logic [3:0] count_q, count_d;
  logic       full_q, full_d;
  logic       steal_q, steal_d;

  logic       hit;
  logic [3:0] hit_idx;
  logic       free_found;
  logic [3:0] free_idx;
  logic       free_after;

  // Parallel search for the held note and the lowest free slot; descending scan leaves the lowest match.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NBANKS - 1; i >= 0; i--) begin
      if (slot_q[i] == hold_note_q) begin
        hit     = 1'b1;
        hit_idx = 4'(i);
      end
      if (slot_q[i] == 7'd0) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
    end
  end

  // Next-state: stream advance and event application on clk_en, event capture on any edge.
  always_comb begin
    slot_d      = slot_q;
    ctr_d       = ctr_q;
    steal_ptr_d = steal_ptr_q;
    hold_full_d = hold_full_q;
    hold_on_d   = hold_on_q;
    hold_note_d = hold_note_q;
    midi_d      = midi_q;
    slot_out_d  = slot_out_q;
    valid_d     = valid_q;
    count_d     = count_q;
    full_d      = full_q;
    steal_d     = 1'b0;
    free_after  = free_found;

    if (clk_en) begin
      // Stream reads the table before this edge's write lands.
      midi_d     = slot_q[ctr_q];
      slot_out_d = ctr_q;
      valid_d    = (slot_q[ctr_q] != 7'd0);
      ctr_d      = (ctr_q == LAST) ? 4'd0 : ctr_q + 4'd1;

      if (hold_full_q) begin
        hold_full_d = 1'b0;
        if (hold_note_q != 7'd0) begin
          if (hold_on_q) begin
            if (!hit) begin
              if (free_found) begin
                slot_d[free_idx] = hold_note_q;
                count_d          = count_q + 4'd1;
                free_after       = 1'b0;
                for (int i = 0; i < NBANKS; i++) begin
                  if (4'(i) != free_idx && slot_q[i] == 7'd0) free_after = 1'b1;
                end
              end else begin
                slot_d[steal_ptr_q] = hold_note_q;
                steal_d             = 1'b1;
                steal_ptr_d         = (steal_ptr_q == LAST) ? 4'd0 : steal_ptr_q + 4'd1;
              end
            end
          end else if (hit) begin
            slot_d[hit_idx] = 7'd0;
            count_d         = count_q - 4'd1;
            free_after      = 1'b1;
          end
        end
        full_d = !free_after;
      end
    end

    if (i_ev_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_on_d   = i_ev_on;
      hold_note_d = i_ev_note;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBANKS; i++) slot_q[i] <= '0;
      ctr_q       <= '0;
      steal_ptr_q <= '0;
      hold_full_q <= 1'b0;
      hold_on_q   <= 1'b0;
      hold_note_q <= '0;
      midi_q      <= '0;
      slot_out_q  <= '0;
      valid_q     <= 1'b0;
      count_q     <= '0;
      full_q      <= 1'b0;
      steal_q     <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      ctr_q       <= ctr_d;
      steal_ptr_q <= steal_ptr_d;
      hold_full_q <= hold_full_d;
      hold_on_q   <= hold_on_d;
      hold_note_q <= hold_note_d;
      midi_q      <= midi_d;
      slot_out_q  <= slot_out_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      full_q      <= full_d;
      steal_q     <= steal_d;
    end
  end

  assign o_ev_ready     = !hold_full_q;
  assign o_midi         = midi_q;
  assign o_slot         = slot_out_q;
  assign o_valid        = valid_q;
  assign o_active_count = count_q;
  assign o_full         = full_q;
  assign o_steal        = steal_q;

endmodule

// File: doc/voice_allocator_p.md
Name: voice_allocator_p

Overview:
Producer side of the time-multiplexed voice stream consumed by the pipelined phase bank. Accepts note-on/note-off events from the MIDI front end and keeps a table of NBANKS voice slots. Every clk_en cycle it emits one slot's MIDI note, in round-robin slot order, as the per-cycle midi input of the phase bank. MIDI value 0 is reserved as "slot idle", matching the phase bank's silent/invalid encoding.

Parameters:
NBANKS, 10, number of voice slots. Must equal the phase bank's NBANKS; legal range 2..16.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
clk_en  in  1  sample-rate enable; slot table and stream advance only when high
i_ev_valid  in  1  event present
i_ev_on  in  1  1 = note-on, 0 = note-off
i_ev_note  in  7  event MIDI note
o_ev_ready  out  1  event holding register empty; event accepted on clk edge with i_ev_valid && o_ev_ready
o_midi  out  7  note for current slot (0 = idle); feeds phase bank i_midi
o_slot  out  4  index of slot shown on o_midi
o_valid  out  1  o_midi != 0
o_active_count  out  4  number of occupied slots
o_full  out  1  all NBANKS slots occupied
o_steal  out  1  one-cycle pulse when a note-on evicted a slot

Behaviour:
- Reset (async, any time including mid-event): all slots = 0; slot counter = 0; steal pointer = 0; holding register empty. Outputs: o_midi = 0, o_slot = 0, o_valid = 0, o_active_count = 0, o_full = 0, o_steal = 0, o_ev_ready = 1. Any pending event is discarded.
- Handshake:
  - o_ev_ready = !hold_full (registered).
  - Accept on any clk edge with i_ev_valid && o_ev_ready, independent of clk_en; hold_full is set.
  - The held event is applied at the first clk_en edge strictly after acceptance, then hold_full clears.
  - So o_ev_ready is low for at least one cycle and stays low while clk_en is low.
- Event application (clk_en edge with hold_full):
  - Note 0: dropped, no table change.
  - Note-on, note already in a slot: no change (no retrigger, no duplicate).
  - Note-on, free slot exists: write to lowest-index slot whose value is 0.
  - Note-on, table full: overwrite slot[steal_ptr]; o_steal = 1 for one clk cycle; steal_ptr increments, wrapping NBANKS-1 -> 0.
  - Note-off: clear the slot holding that note. Absent note: no change.
  - Duplicate search and free-slot search are combinational over all slots, completing in the same cycle.
- Stream, at every clk_en edge:
  - o_midi <= slot[ctr]; o_slot <= ctr; o_valid <= (slot[ctr] != 0).
  - ctr increments, wrapping NBANKS-1 -> 0.
  - The first clk_en edge after reset emits slot 0.
- Read-before-write: if an event writes slot k on the same edge slot k is emitted, o_midi carries the old value. The new value appears on the next visit to slot k (NBANKS clk_en edges later).
- clk_en low: stream outputs, ctr, table and steal_ptr all hold. o_steal deasserts after its single cycle.
- o_active_count / o_full: registered, updated on the same edge as the table write. o_full = (count == NBANKS).
- Combinational logic must not depend on o_ outputs.

Test Plan:
1. Reset, then 12 cycles with clk_en = 1 -> o_slot = 0,1,...,9,0,1; o_midi = 0; o_valid = 0; o_ev_ready = 1; o_active_count = 0.
2. Note-on 0x45 -> o_ev_ready low one cycle; slot 0 = 0x45; next emission of slot 0 gives o_midi = 0x45, o_valid = 1; o_active_count = 1.
3. Note-on 0x45 again -> no change, count = 1. Note-off 0x45 -> slot 0 = 0, count = 0. Note-off 0x22 (absent) -> no change.
4. Note-ons 0x30..0x39 -> slots 0..9, o_full = 1, count = 10. Note-on 0x3A -> slot 0 = 0x3A, o_steal pulse, steal_ptr = 1. Note-on 0x3B -> slot 1 = 0x3B.
5. From the full table, note-off 0x33 -> slot 3 freed, o_full = 0. Note-on 0x50 -> slot 3 = 0x50, no steal.
6. clk_en held low with a note-on 0x40 accepted -> o_ev_ready stays 0 and the stream is frozen. clk_en high -> applied to the lowest free slot. Event with note 0 -> accepted and dropped. Assert rst mid-stream -> all outputs return to reset values immediately, without a clock edge.
